// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment glyph constants and code-to-glyph helper
package seg7_pkg;

  // Segment order {g,f,e,d,c,b,a}, active low (common-anode digits).
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_en);
    logic [6:0] g;
    case (code)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    // Decimal-only displays show nothing for letter codes.
    if (code > 4'h9 && !hex_en) begin
      g = SEG_OFF;
    end
    return g;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational 4-bit code to active-low glyph
module seg7_decoder
  import seg7_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = seg7_glyph(code, HEX_EN);

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed common-anode 7-seg driver with dead-time blanking
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter bit HEX_EN       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digit_code,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_on,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int SLOT  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SC_W  = (SLOT < 2) ? 1 : $clog2(SLOT);
  localparam int IDX_W = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS);

  generate
    if (NUM_DIGITS < 2 || SLOT < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT) begin : g_bad_params
      $error("seg7_scan_mux: need NUM_DIGITS >= 2, SLOT >= 2 and 1 <= BLANK_CYCLES < SLOT");
    end
  endgenerate

  logic [SC_W-1:0]  slot_cnt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       snap_code;
  logic             snap_dp;
  logic             snap_on;
  logic [6:0]       dec_seg;

  logic slot_last;
  logic idx_last;
  logic snap_now;
  logic show;

  assign slot_last = (slot_cnt == SC_W'(SLOT - 1));
  assign idx_last  = (idx == IDX_W'(NUM_DIGITS - 1));
  assign snap_now  = (slot_cnt == SC_W'(BLANK_CYCLES - 1));
  assign show      = (slot_cnt >= SC_W'(BLANK_CYCLES));

  seg7_decoder #(
    .HEX_EN (HEX_EN)
  ) u_decoder (
    .code (snap_code),
    .seg  (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      idx        <= '0;
      snap_code  <= '0;
      snap_dp    <= 1'b0;
      snap_on    <= 1'b0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else if (!en) begin
      slot_cnt   <= '0;
      idx        <= '0;
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= idx_last ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      frame_tick <= slot_last && idx_last;

      // Latch the digit while it is still blanked so SHOW never tears mid-slot.
      if (snap_now) begin
        snap_code <= digit_code[{idx, 2'b00} +: 4];
        snap_dp   <= dp_in[idx];
        snap_on   <= digit_on[idx];
      end

      if (show) begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= snap_on ? dec_seg : SEG_OFF;
        dp  <= ~(snap_on & snap_dp);
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux (decimal and hex builds)
module tb_seg7_scan_mux;

  localparam int N     = 4;
  localparam int SLOT  = 25;
  localparam int BLANK = 3;
  localparam int FRAME = SLOT * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic [15:0]   digit_code = 16'h1234;
  logic [3:0]    dp_in      = 4'b0100;
  logic [3:0]    digit_on   = 4'hF;

  logic [3:0]    an0, an1;
  logic [6:0]    seg0, seg1;
  logic          dp0, dp1, ft0, ft1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS(N), .CLK_HZ(1000), .REFRESH_HZ(10), .BLANK_CYCLES(BLANK), .HEX_EN(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .digit_code(digit_code), .dp_in(dp_in),
    .digit_on(digit_on), .an(an0), .seg(seg0), .dp(dp0), .frame_tick(ft0)
  );

  seg7_scan_mux #(
    .NUM_DIGITS(N), .CLK_HZ(1000), .REFRESH_HZ(10), .BLANK_CYCLES(BLANK), .HEX_EN(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .digit_code(digit_code), .dp_in(dp_in),
    .digit_on(digit_on), .an(an1), .seg(seg1), .dp(dp1), .frame_tick(ft1)
  );

  function automatic logic [6:0] tb_glyph(input logic [3:0] c, input bit hex);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;  4'd3: return 7'h30;
      4'd4: return 7'h19;  4'd5: return 7'h12;  4'd6: return 7'h02;  4'd7: return 7'h78;
      4'd8: return 7'h00;  4'd9: return 7'h10;
      4'd10: return hex ? 7'h08 : 7'h7F;
      4'd11: return hex ? 7'h03 : 7'h7F;
      4'd12: return hex ? 7'h46 : 7'h7F;
      4'd13: return hex ? 7'h21 : 7'h7F;
      4'd14: return hex ? 7'h06 : 7'h7F;
      default: return hex ? 7'h0E : 7'h7F;
    endcase
  endfunction

  // Reference: k = enabled cycles since scanning (re)started; position in the frame is plain arithmetic.
  int         k = 0;
  int         m_pos, m_d, m_s;
  logic [3:0] m_code = '0;
  logic       m_dpv = 1'b0;
  logic       m_on  = 1'b0;
  logic       mv = 1'b0;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg0 = 7'h7F, exp_seg1 = 7'h7F;
  logic       exp_dp = 1'b1, exp_ft = 1'b0;

  always_comb begin
    m_pos = k % FRAME;
    m_d   = m_pos / SLOT;
    m_s   = m_pos % SLOT;
  end

  always @(posedge clk) begin
    mv <= 1'b1;
    if (rst || !en) begin
      k        <= 0;
      exp_an   <= 4'hF;
      exp_seg0 <= 7'h7F;
      exp_seg1 <= 7'h7F;
      exp_dp   <= 1'b1;
      exp_ft   <= 1'b0;
    end else begin
      k      <= k + 1;
      exp_ft <= (m_pos == FRAME - 1);
      if (m_s == BLANK - 1) begin
        m_code <= digit_code[4*m_d +: 4];
        m_dpv  <= dp_in[m_d];
        m_on   <= digit_on[m_d];
      end
      if (m_s < BLANK) begin
        exp_an   <= 4'hF;
        exp_seg0 <= 7'h7F;
        exp_seg1 <= 7'h7F;
        exp_dp   <= 1'b1;
      end else begin
        exp_an   <= 4'hF ^ (4'h1 << m_d);
        exp_seg0 <= m_on ? tb_glyph(m_code, 1'b0) : 7'h7F;
        exp_seg1 <= m_on ? tb_glyph(m_code, 1'b1) : 7'h7F;
        exp_dp   <= !(m_on && m_dpv);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  logic [3:0] last_low = 4'hF;
  int         gap = 0;

  // One cycle: sample at the falling edge, compare both builds against the reference, watch dead time.
  task automatic step();
    @(negedge clk);
    if (mv) begin
      chk("an0", an0, exp_an);
      chk("seg0", seg0, exp_seg0);
      chk("dp0", dp0, exp_dp);
      chk("ft0", ft0, exp_ft);
      chk("an1", an1, exp_an);
      chk("seg1", seg1, exp_seg1);
      chk("dp1", dp1, exp_dp);
      chk("ft1", ft1, exp_ft);
      chk("an_onehot", ($countones(~an0) <= 1), 1);
      if (an0 == 4'hF) begin
        gap++;
      end else begin
        if (last_low != 4'hF && an0 != last_low) chk("dead_time", (gap >= BLANK), 1);
        last_low = an0;
        gap      = 0;
      end
    end
  endtask

  task automatic wait_an(input logic [3:0] v, input string nm);
    int n = 0;
    while (an0 !== v && n < 300) begin
      step();
      n++;
    end
    chk(nm, an0, v);
  endtask

  task automatic wait_ft(input string nm);
    int n = 0;
    do begin
      step();
      n++;
    end while (ft0 !== 1'b1 && n < 250);
    chk(nm, ft0, 1);
  endtask

  initial begin
    int n;
    // 1: reset holds outputs dark; first anode 3 blank + 1 register cycles after release
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_an", an0, 4'hF);
      chk("rst_seg", seg0, 7'h7F);
      chk("rst_dp", dp0, 1);
    end
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (an0 !== 4'hE && n < 50);
    chk("first_an_latency", n, 4);

    // 2: digit order, glyphs and DP for 1234
    chk("d0_seg", seg0, 7'h19);
    chk("d0_dp", dp0, 1);
    wait_an(4'hD, "reach_d1");
    chk("d1_seg", seg0, 7'h30);
    wait_an(4'hB, "reach_d2");
    chk("d2_seg", seg0, 7'h24);
    chk("d2_dp", dp0, 0);
    wait_an(4'h7, "reach_d3");
    chk("d3_seg", seg0, 7'h79);
    chk("d3_dp", dp0, 1);
    wait_ft("ft_first");
    n = 0;
    do begin
      step();
      n++;
    end while (ft0 !== 1'b1 && n < 250);
    chk("frame_period", n, FRAME);

    // 3: mid-slot code change must not tear the glyph
    digit_code = 16'h1235;
    wait_an(4'hE, "reach_d0_five");
    chk("d0_five", seg0, 7'h12);
    repeat (6) step();
    digit_code = 16'h1238;
    n = 0;
    while (an0 == 4'hE && n < 30) begin
      chk("no_tear", seg0, 7'h12);
      step();
      n++;
    end
    wait_an(4'hE, "reach_d0_eight");
    chk("d0_eight", seg0, 7'h00);

    // 4: long run under the per-cycle monitor
    repeat (1000) step();

    // 5: letter codes, decimal vs hex build, forced-blank digit 3
    wait_ft("ft_hex");
    digit_code = 16'hABCD;
    digit_on   = 4'b0111;
    dp_in      = 4'b0000;
    wait_an(4'hE, "hex_d0");
    chk("dec_d0", seg0, 7'h7F);
    chk("hex_d0_seg", seg1, 7'h21);
    wait_an(4'hD, "hex_d1");
    chk("hex_d1_seg", seg1, 7'h46);
    wait_an(4'hB, "hex_d2");
    chk("hex_d2_seg", seg1, 7'h03);
    chk("dec_d2", seg0, 7'h7F);
    wait_an(4'h7, "hex_d3");
    chk("hex_d3_dark", seg1, 7'h7F);
    chk("hex_d3_an", an1, 4'h7);

    // 6: enable drop mid-SHOW of digit 2, then restart at digit 0
    digit_on = 4'hF;
    wait_ft("ft_en");
    wait_an(4'hB, "en_d2");
    step();
    en = 1'b0;
    step();
    chk("en_off_an", an0, 4'hF);
    chk("en_off_seg", seg0, 7'h7F);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("en_off_ft", ft0, 0);
      chk("en_off_dark", an0, 4'hF);
    end
    en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (an0 !== 4'hE && n < 50);
    chk("en_restart_latency", n, 4);
    repeat (200) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
